// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution unit:
// ARM condition codes, NZCV flag indices, FlagW groups and IT-block state.
package cond_pkg;

   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_CS = 4'd2;
   localparam logic [3:0] COND_CC = 4'd3;
   localparam logic [3:0] COND_MI = 4'd4;
   localparam logic [3:0] COND_PL = 4'd5;
   localparam logic [3:0] COND_VS = 4'd6;
   localparam logic [3:0] COND_VC = 4'd7;
   localparam logic [3:0] COND_HI = 4'd8;
   localparam logic [3:0] COND_LS = 4'd9;
   localparam logic [3:0] COND_GE = 4'd10;
   localparam logic [3:0] COND_LT = 4'd11;
   localparam logic [3:0] COND_GT = 4'd12;
   localparam logic [3:0] COND_LE = 4'd13;
   localparam logic [3:0] COND_AL = 4'd14;
   localparam logic [3:0] COND_NV = 4'd15;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // FlagW encodings and the bit that enables each group
   localparam logic [1:0] FW_NONE = 2'b00;
   localparam logic [1:0] FW_CV   = 2'b01;
   localparam logic [1:0] FW_NZ   = 2'b10;
   localparam logic [1:0] FW_NZCV = 2'b11;
   localparam int FW_NZ_BIT = 1;
   localparam int FW_CV_BIT = 0;

   // Storage width for the IT mask; the sequencer covers up to 4 slots
   localparam int IT_MASK_W = 4;

   typedef struct packed {
      logic [3:0]           base;
      logic [IT_MASK_W-1:0] mask;
      logic [1:0]           slot;
      logic [2:0]           remaining;
   } it_state_t;

   typedef enum logic {
      IT_IDLE   = 1'b0,
      IT_ACTIVE = 1'b1
   } it_fsm_e;

   // Condition of the current IT slot: mask bit 0 selects the inverse
   function automatic logic [3:0] slot_cond(it_state_t s);
      return {s.base[3:1], s.base[0] ^ ~s.mask[s.slot]};
   endfunction

endpackage

// File: rtl/condlogic_it_if.sv
// Controller <-> conditional-execution unit bundle.
// master: controller drives requests; slave: condlogic_it drives gated enables.
interface condlogic_it_if #(
   parameter int NUM_WR     = 2,
   parameter int IT_MAX_LEN = 4
);
   logic                  InstrStart;
   logic                  InstrDone;
   logic                  Flush;
   logic [3:0]            Cond;
   logic [3:0]            ALUFlags;
   logic [1:0]            FlagW;
   logic                  PCS;
   logic                  NextPC;
   logic [NUM_WR-1:0]     RegW;
   logic                  MemW;
   logic                  ITStart;
   logic [3:0]            ITFirstCond;
   logic [2:0]            ITLen;
   logic [IT_MAX_LEN-1:0] ITMask;

   logic                  PCWrite;
   logic [NUM_WR-1:0]     RegWrite;
   logic                  MemWrite;
   logic [3:0]            Flags;
   logic                  InIT;
   logic                  ITErr;

   modport master (
      output InstrStart, InstrDone, Flush, Cond, ALUFlags, FlagW,
      output PCS, NextPC, RegW, MemW,
      output ITStart, ITFirstCond, ITLen, ITMask,
      input  PCWrite, RegWrite, MemWrite, Flags, InIT, ITErr
   );

   modport slave (
      input  InstrStart, InstrDone, Flush, Cond, ALUFlags, FlagW,
      input  PCS, NextPC, RegW, MemW,
      input  ITStart, ITFirstCond, ITLen, ITMask,
      output PCWrite, RegWrite, MemWrite, Flags, InIT, ITErr
   );
endinterface

// File: rtl/condcheck.sv
// Combinational ARM condition evaluator.
// cond_i: cond field, flags_i: NZCV, cond_ex_o: condition holds.
module condcheck
   import cond_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] flags_i,
   output logic       cond_ex_o
);

   logic n, z, c, v, ge;

   assign n  = flags_i[FLAG_N];
   assign z  = flags_i[FLAG_Z];
   assign c  = flags_i[FLAG_C];
   assign v  = flags_i[FLAG_V];
   assign ge = (n == v);

   always_comb begin
      cond_ex_o = 1'b0;
      unique case (cond_i)
         COND_EQ: cond_ex_o = z;
         COND_NE: cond_ex_o = ~z;
         COND_CS: cond_ex_o = c;
         COND_CC: cond_ex_o = ~c;
         COND_MI: cond_ex_o = n;
         COND_PL: cond_ex_o = ~n;
         COND_VS: cond_ex_o = v;
         COND_VC: cond_ex_o = ~v;
         COND_HI: cond_ex_o = c & ~z;
         COND_LS: cond_ex_o = ~(c & ~z);
         COND_GE: cond_ex_o = ge;
         COND_LT: cond_ex_o = ~ge;
         COND_GT: cond_ex_o = ~z & ge;
         COND_LE: cond_ex_o = ~(~z & ge);
         COND_AL: cond_ex_o = 1'b1;
         COND_NV: cond_ex_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset.
// en_i: load enable, d_i: next value, q_o: held value.
module flopenr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   always_ff @(posedge clk) begin
      if (reset)     q_o <= '0;
      else if (en_i) q_o <= d_i;
   end

endmodule

// File: rtl/flopr.sv
// Register with synchronous active-high reset.
// d_i: next value, q_o: held value (cleared by reset).
module flopr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   always_ff @(posedge clk) begin
      if (reset) q_o <= '0;
      else       q_o <= d_i;
   end

endmodule

// File: rtl/it_seq.sv
// IT-block sequencer: tracks base cond, mask, slot and slots remaining.
// Outputs in_it_o, per-slot it_cond_o and a one-cycle it_err_o pulse.
module it_seq
   import cond_pkg::*;
#(
   parameter int IT_MAX_LEN = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  instr_done_i,
   input  logic                  flush_i,
   input  logic                  it_start_i,
   input  logic [3:0]            first_cond_i,
   input  logic [2:0]            len_i,
   input  logic [IT_MAX_LEN-1:0] mask_i,
   output logic                  in_it_o,
   output logic [3:0]            it_cond_o,
   output logic                  it_err_o
);

   localparam logic [2:0] MAX_LEN = 3'(IT_MAX_LEN);

   it_fsm_e              state_q, state_d;
   it_state_t            it_q, it_d;
   logic                 err_q, err_d;
   logic [IT_MASK_W-1:0] mask_ext;
   logic                 bad_len, bad_al;

   // Slot 0 always uses the base condition
   always_comb begin
      mask_ext = '0;
      mask_ext[IT_MAX_LEN-1:0] = mask_i;
      mask_ext[0] = 1'b1;
   end

   assign bad_len = (len_i == 3'd0) || (len_i > MAX_LEN);

   // AL has no inverse, so an else-slot under AL is rejected
   always_comb begin
      bad_al = 1'b0;
      for (int i = 1; i < IT_MASK_W; i++) begin
         if (3'(i) < len_i && !mask_ext[i])
            bad_al = 1'b1;
      end
      if (first_cond_i != COND_AL)
         bad_al = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      it_d    = it_q;
      err_d   = 1'b0;
      if (flush_i) begin
         state_d = IT_IDLE;
         it_d    = '0;
      end else if (it_start_i) begin
         if (state_q == IT_ACTIVE || bad_len || bad_al) begin
            err_d = 1'b1;
         end else begin
            state_d        = IT_ACTIVE;
            it_d.base      = first_cond_i;
            it_d.mask      = mask_ext;
            it_d.slot      = 2'd0;
            it_d.remaining = len_i;
         end
      end else if (state_q == IT_ACTIVE && instr_done_i) begin
         it_d.slot      = it_q.slot + 2'd1;
         it_d.remaining = it_q.remaining - 3'd1;
         if (it_q.remaining == 3'd1) begin
            state_d = IT_IDLE;
            it_d    = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IT_IDLE;
         it_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         it_q    <= it_d;
         err_q   <= err_d;
      end
   end

   assign in_it_o   = (state_q == IT_ACTIVE);
   assign it_cond_o = slot_cond(it_q);
   assign it_err_o  = err_q;

endmodule

// File: rtl/condlogic_it.sv
// Conditional-execution unit: NZCV flags, held condition, write gating, IT.
// clk/reset plain ports; all controller traffic on bus (slave modport).
module condlogic_it
   import cond_pkg::*;
#(
   parameter int NUM_WR     = 2,
   parameter int IT_MAX_LEN = 4
) (
   input  logic           clk,
   input  logic           reset,
   condlogic_it_if.slave  bus
);

   logic [1:0] nz_q, cv_q;
   logic [3:0] flags_q;
   logic       cond_q, cond_d;
   logic       in_it, it_err;
   logic [3:0] it_cond, ec;
   logic       cond_live, cond_eff;
   logic [1:0] flag_write;

   it_seq #(.IT_MAX_LEN(IT_MAX_LEN)) u_it (
      .clk          (clk),
      .reset        (reset),
      .instr_done_i (bus.InstrDone),
      .flush_i      (bus.Flush),
      .it_start_i   (bus.ITStart),
      .first_cond_i (bus.ITFirstCond),
      .len_i        (bus.ITLen),
      .mask_i       (bus.ITMask),
      .in_it_o      (in_it),
      .it_cond_o    (it_cond),
      .it_err_o     (it_err)
   );

   assign ec = in_it ? it_cond : bus.Cond;

   condcheck u_cc (
      .cond_i    (ec),
      .flags_i   (flags_q),
      .cond_ex_o (cond_live)
   );

   // Evaluate once on the first cycle, then hold for the instruction
   assign cond_eff = bus.InstrStart ? cond_live : cond_q;
   assign cond_d   = bus.Flush ? 1'b0 : cond_eff;

   flopr #(.WIDTH(1)) u_condreg (
      .clk   (clk),
      .reset (reset),
      .d_i   (cond_d),
      .q_o   (cond_q)
   );

   assign flag_write = bus.FlagW & {2{cond_eff & ~reset}};

   flopenr #(.WIDTH(2)) u_nz (
      .clk   (clk),
      .reset (reset),
      .en_i  (flag_write[FW_NZ_BIT]),
      .d_i   (bus.ALUFlags[FLAG_N:FLAG_Z]),
      .q_o   (nz_q)
   );

   flopenr #(.WIDTH(2)) u_cv (
      .clk   (clk),
      .reset (reset),
      .en_i  (flag_write[FW_CV_BIT]),
      .d_i   (bus.ALUFlags[FLAG_C:FLAG_V]),
      .q_o   (cv_q)
   );

   assign flags_q = {nz_q, cv_q};

   assign bus.RegWrite = reset ? '0
                       : bus.RegW & {NUM_WR{cond_eff}};
   assign bus.MemWrite = ~reset & bus.MemW & cond_eff;
   assign bus.PCWrite  = ~reset &
                         (bus.PCS | (bus.NextPC & cond_eff));
   assign bus.Flags    = flags_q;
   assign bus.InIT     = in_it;
   assign bus.ITErr    = it_err;

endmodule
